// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver.
// Glyph codes are active-low {A,B,C,D,E,F,G}: a 0 bit lights the segment.
package seven_seg_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  // Index width that stays >= 1 even for a single-digit display.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational nibble -> active-low 7-segment glyph (0-9, A, b, C, d, E, F).
// Ports: nib  in  4  hex digit
//        seg  out 7  {A..G}, 0 = lit
module hex_to_seg7
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed common-anode 7-segment driver.
// Ports:
//   Clk, Rst_n          clock (rising), async active-low reset
//   Value[4*DIGITS]     packed nibbles, Value[3:0] = rightmost digit
//   Load                1-cycle strobe capturing Value/Dp/Lz_En into the shadow
//   Dp[DIGITS]          decimal point per digit
//   Lz_En               blank leading zeros (digit 0 always shown)
//   Busy                shadow holds a value not yet on the display
//   Frame_Tick          1-cycle pulse after the digit index wraps to 0
//   An[DIGITS]          digit enables, Seg[6:0] {A..G}, Dp_Out   (pin polarity per params)
// New values only reach the display registers at the frame boundary so a frame is
// never drawn half-old/half-new.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic                  Load,
  input  logic [DIGITS-1:0]     Dp,
  input  logic                  Lz_En,
  output logic                  Busy,
  output logic                  Frame_Tick,
  output logic [DIGITS-1:0]     An,
  output logic [6:0]            Seg,
  output logic                  Dp_Out
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = idx_width(DIGITS);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACT_LOW}};
  localparam logic [6:0]        SEG_PIN_OFF = {7{SEG_ACT_LOW}};
  localparam logic              DP_PIN_OFF  = SEG_ACT_LOW;

  logic [PRE_W-1:0]           pre_q, pre_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]     sh_val_q, sh_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]          sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]          mask_q, mask_d;
  logic                       sh_lz_q, sh_lz_d;
  logic                       busy_q, busy_d, tick_q, tick_d;
  logic [DIGITS-1:0]          an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dpo_q, dpo_d;

  logic [DIGITS-1:0][3:0]     value_nib;
  logic                       slot_end, frame_end, in_blank, cur_masked;
  logic [3:0]                 cur_nib;
  logic [6:0]                 glyph;

  assign value_nib = Value;

  // Digit i>0 is blanked when enabled and it and every higher nibble are zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [DIGITS-1:0][3:0] v,
                                                input logic en);
    logic [DIGITS-1:0] m;
    logic upper_zero;
    m = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (v[i] == 4'h0);
      m[i] = en & upper_zero;
    end
    return m;
  endfunction

  assign cur_nib    = disp_val_q[idx_q];
  assign cur_masked = mask_q[idx_q];

  hex_to_seg7 u_dec (
    .nib (cur_nib),
    .seg (glyph)
  );

  always_comb begin
    slot_end  = (pre_q == PRE_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    in_blank  = (32'(pre_q) < 32'(BLANK_CYC));

    pre_d = slot_end ? '0 : pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);

    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    sh_lz_d    = sh_lz_q;
    busy_d     = busy_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    mask_d     = mask_q;

    if (Load) begin
      sh_val_d = value_nib;
      sh_dp_d  = Dp;
      sh_lz_d  = Lz_En;
    end

    if (frame_end) begin
      busy_d = 1'b0;
      // A Load on the boundary cycle bypasses the shadow so it lands this frame.
      if (Load) begin
        disp_val_d = value_nib;
        disp_dp_d  = Dp;
        mask_d     = lz_mask(value_nib, Lz_En);
      end else if (busy_q) begin
        disp_val_d = sh_val_q;
        disp_dp_d  = sh_dp_q;
        mask_d     = lz_mask(sh_val_q, sh_lz_q);
      end
    end else if (Load) begin
      busy_d = 1'b1;
    end

    tick_d = frame_end;

    // Pin outputs are registered from the current index, so they lag it by one clock.
    an_d = AN_OFF;
    if (!in_blank && !cur_masked) an_d = AN_OFF ^ (DIGITS'(1) << idx_q);
    seg_d = cur_masked ? SEG_PIN_OFF : (glyph ^ ~SEG_PIN_OFF);
    dpo_d = cur_masked ? DP_PIN_OFF : (disp_dp_q[idx_q] ^ DP_PIN_OFF);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pre_q      <= '0;
      idx_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      sh_lz_q    <= 1'b0;
      busy_q     <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      mask_q     <= '0;
      tick_q     <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_PIN_OFF;
      dpo_q      <= DP_PIN_OFF;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      sh_lz_q    <= sh_lz_d;
      busy_q     <= busy_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      mask_q     <= mask_d;
      tick_q     <= tick_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dpo_q      <= dpo_d;
    end
  end

  assign Busy       = busy_q;
  assign Frame_Tick = tick_q;
  assign An         = an_q;
  assign Seg        = seg_q;
  assign Dp_Out     = dpo_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, active-low pins).
// The reference model derives slot/index from elapsed clocks since reset and holds
// pending/displayed values as plain variables.
module tb_seven_seg_scan_driver;

  localparam int D = 4;
  localparam int R = 4;
  localparam int B = 1;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [15:0] Value = '0;
  logic        Load = 1'b0;
  logic [3:0]  Dp = '0;
  logic        Lz_En = 1'b0;
  logic        Busy, Frame_Tick, Dp_Out;
  logic [3:0]  An;
  logic [6:0]  Seg;

  seven_seg_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(R), .BLANK_CYC(B), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Value(Value), .Load(Load), .Dp(Dp), .Lz_En(Lz_En),
    .Busy(Busy), .Frame_Tick(Frame_Tick), .An(An), .Seg(Seg), .Dp_Out(Dp_Out)
  );

  always #5 Clk = ~Clk;

  wire [13:0] obs = {An, Seg, Dp_Out, Busy, Frame_Tick};
  localparam logic [13:0] OFF_V = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

  logic [6:0] gly [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int vec = 0;
  int bad = 0;

  // model state
  int          n;
  bit          pend;
  logic [15:0] p_val, d_val;
  logic [3:0]  p_dp, d_dp;
  logic        p_lz, d_lz;
  logic [13:0] exp_v;

  task automatic model_reset();
    n = 0; pend = 0;
    p_val = '0; d_val = '0; p_dp = '0; d_dp = '0; p_lz = 0; d_lz = 0;
    exp_v = OFF_V;
  endtask

  // Drive inputs for one clock, advance the model, return at the following negedge.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz);
    int pre, idx;
    bit bnd, msk;
    logic [3:0] an, nib;
    logic [6:0] sg;
    logic dpb;
    Load = ld; Value = v; Dp = d; Lz_En = lz;
    @(posedge Clk);
    pre = n % R;
    idx = (n / R) % D;
    bnd = (pre == R - 1) && (idx == D - 1);
    msk = (idx > 0) && d_lz && ((d_val >> (4 * idx)) == 16'h0);
    nib = 4'((d_val >> (4 * idx)) & 16'hF);
    an  = (pre < B || msk) ? 4'hF : ~(4'b0001 << idx);
    sg  = msk ? 7'h7F : gly[nib];
    dpb = msk ? 1'b1 : ~d_dp[idx];
    if (bnd) begin
      if (ld) begin d_val = v; d_dp = d; d_lz = lz; end
      else if (pend) begin d_val = p_val; d_dp = p_dp; d_lz = p_lz; end
      pend = 0;
    end else if (ld) begin
      p_val = v; p_dp = d; p_lz = lz; pend = 1;
    end
    exp_v = {an, sg, dpb, pend, bnd};
    n++;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #1;
    model_reset();
    vec++; if (obs !== OFF_V) begin bad++; $display("FAIL reset_async got=%h want=%h", obs, OFF_V); end
    repeat (2) begin
      @(negedge Clk);
      vec++; if (obs !== OFF_V) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, OFF_V); end
    end
    Rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(0, 16'($urandom), 4'($urandom), 1'($urandom));
      vec++; if (obs !== exp_v) begin bad++; $display("FAIL reset_release n=%0d got=%h want=%h", n, obs, exp_v); end
    end
    vec++; if (An !== 4'hE) begin bad++; $display("FAIL first_anode got=%h want=e", An); end
  endtask

  task automatic test_glyphs();
    logic [15:0] vals [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 2 * D * R + 1; k++) begin
        step(k == 0, (k == 0) ? vals[j] : 16'($urandom), 4'($urandom), (k == 0) ? 1'b0 : 1'($urandom));
        vec++; if (obs !== exp_v) begin bad++; $display("FAIL glyphs n=%0d got=%h want=%h", n, obs, exp_v); end
      end
    end
  endtask

  task automatic test_pending();
    while (n % (D * R) != 5) step(0, '0, '0, 0);
    step(1, 16'h1234, 4'b0010, 0);
    vec++; if (Busy !== 1'b1) begin bad++; $display("FAIL pending_busy got=%b want=1", Busy); end
    for (int k = 0; k < 2 * D * R; k++) begin
      step(0, 16'($urandom), 4'($urandom), 1'($urandom));
      vec++; if (obs !== exp_v) begin bad++; $display("FAIL pending n=%0d got=%h want=%h", n, obs, exp_v); end
    end
    vec++; if (Busy !== 1'b0) begin bad++; $display("FAIL pending_clear got=%b want=0", Busy); end
  endtask

  task automatic test_lz();
    int lit_hi, lit_other;
    lit_hi = 0; lit_other = 0;
    for (int k = 0; k < 2 * D * R + 1; k++) begin
      step(k == 0, (k == 0) ? 16'h0070 : 16'($urandom), 4'($urandom), (k == 0) ? 1'b1 : 1'($urandom));
      vec++; if (obs !== exp_v) begin bad++; $display("FAIL lz_0070 n=%0d got=%h want=%h", n, obs, exp_v); end
      if (k > D * R && (An[3] === 1'b0 || An[2] === 1'b0)) lit_hi++;
    end
    vec++; if (lit_hi != 0) begin bad++; $display("FAIL lz_upper_lit got=%0d want=0", lit_hi); end
    for (int k = 0; k < 2 * D * R + 1; k++) begin
      step(k == 0, (k == 0) ? 16'h0000 : 16'($urandom), 4'b0000, (k == 0) ? 1'b1 : 1'($urandom));
      vec++; if (obs !== exp_v) begin bad++; $display("FAIL lz_0000 n=%0d got=%h want=%h", n, obs, exp_v); end
      if (k > D * R && An !== 4'hF && An !== 4'hE) lit_other++;
    end
    vec++; if (lit_other != 0) begin bad++; $display("FAIL lz_zero_only got=%0d want=0", lit_other); end
  endtask

  task automatic test_boundary_load();
    int busy_seen;
    busy_seen = 0;
    while (n % (D * R) != D * R - 1) step(0, '0, '0, 0);
    step(1, 16'hA5C3, 4'b0101, 0);
    vec++; if ({Busy, Frame_Tick} !== 2'b01) begin bad++; $display("FAIL bnd_load busy/tick got=%b want=01", {Busy, Frame_Tick}); end
    for (int k = 0; k < D * R + 1; k++) begin
      step(0, 16'($urandom), 4'($urandom), 1'($urandom));
      vec++; if (obs !== exp_v) begin bad++; $display("FAIL bnd_frame n=%0d got=%h want=%h", n, obs, exp_v); end
      if (Busy !== 1'b0) busy_seen++;
    end
    vec++; if (busy_seen != 0) begin bad++; $display("FAIL bnd_busy_rose got=%0d want=0", busy_seen); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      step(($urandom % 6) == 0, 16'($urandom), 4'($urandom), 1'($urandom));
      vec++; if (obs !== exp_v) begin bad++; $display("FAIL random n=%0d got=%h want=%h", n, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    while (n % (D * R) != 6) step(0, '0, '0, 0);
    step(1, 16'h9876, 4'b1111, 0);
    step(0, '0, '0, 0);
    #2 Rst_n = 1'b0;
    #1;
    model_reset();
    vec++; if (obs !== OFF_V) begin bad++; $display("FAIL reset_mid got=%h want=%h", obs, OFF_V); end
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 2 * D * R; k++) begin
      step(0, 16'($urandom), 4'($urandom), 1'($urandom));
      vec++; if (obs !== exp_v) begin bad++; $display("FAIL reset_mid_after n=%0d got=%h want=%h", n, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_glyphs();
    test_pending();
    test_lz();
    test_boundary_load();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
